// File: rtl/traffic_light_monitor.sv
// ---------------------------------------------------------------------------
// traffic_light_monitor
//
// Receiving end of the lamp interface driven by the traffic light controller.
// The three lamp lines are registered once. The phase FSM then works on that
// registered sample, so a lamp change shows up on `phase` two edges after it
// appears on the inputs. For each phase the monitor measures the length in
// clock cycles, reports it when the phase ends, and checks it against the
// nominal timing. Sticky fault flags record illegal lamp combinations,
// sequence errors, timing errors and dark periods for the maintenance logic.
//
// Ports
//   clk          rising-edge clock
//   rst_n        synchronous active-low reset
//   redlight     red lamp from the controller
//   oralight     orange lamp from the controller
//   grelight     green lamp from the controller
//   clr_fault    clears all sticky fault flags (a new fault on the same edge
//                still sets its flag)
//   phase        0=SYNC/unknown, 1=RED, 2=ORANGE, 3=GREEN
//   dur          length in cycles of the last completed phase
//   dur_valid    one-cycle pulse when dur is updated
//   cycle_cnt    number of legal GREEN->RED transitions, wraps at 255
//   fault_multi  sticky: more than one lamp was on
//   fault_dark   sticky: all lamps were off for more than DARK_MAX samples
//   fault_seq    sticky: the phase order was illegal
//   fault_time   sticky: a phase length was outside nominal +/- TOL
//   fault        OR of the four fault flags
// ---------------------------------------------------------------------------
module traffic_light_monitor #(
    parameter int RED_TIME    = 9,
    parameter int ORANGE_TIME = 3,
    parameter int GREEN_TIME  = 12,
    parameter int TOL         = 1,
    parameter int DARK_MAX    = 2,
    parameter int CNT_W       = 6
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             redlight,
    input  logic             oralight,
    input  logic             grelight,
    input  logic             clr_fault,
    output logic [1:0]       phase,
    output logic [CNT_W-1:0] dur,
    output logic             dur_valid,
    output logic [7:0]       cycle_cnt,
    output logic             fault_multi,
    output logic             fault_dark,
    output logic             fault_seq,
    output logic             fault_time,
    output logic             fault
);

    typedef enum logic [1:0] {
        ST_SYNC   = 2'd0,
        ST_RED    = 2'd1,
        ST_ORANGE = 2'd2,
        ST_GREEN  = 2'd3
    } state_t;

    // The dark run counter only needs to reach DARK_MAX+1 and then saturates.
    localparam int DRUN_W = $clog2(DARK_MAX + 2);

    // Lower bound of the tolerance window, clamped at zero.
    function automatic logic [CNT_W:0] lo_of(input int nom);
        int v;
        v = (nom > TOL) ? (nom - TOL) : 0;
        return v[CNT_W:0];
    endfunction

    // Upper bound of the tolerance window.
    function automatic logic [CNT_W:0] hi_of(input int nom);
        int v;
        v = nom + TOL;
        return v[CNT_W:0];
    endfunction

    // First count value that is an overrun.
    function automatic logic [CNT_W:0] ov_of(input int nom);
        int v;
        v = nom + TOL + 1;
        return v[CNT_W:0];
    endfunction

    // Legal phase order RED -> ORANGE -> GREEN -> RED.
    function automatic state_t successor(input state_t s);
        state_t n;
        case (s)
            ST_RED:    n = ST_ORANGE;
            ST_ORANGE: n = ST_GREEN;
            ST_GREEN:  n = ST_RED;
            default:   n = ST_SYNC;
        endcase
        return n;
    endfunction

    localparam logic [CNT_W:0] RED_LO    = lo_of(RED_TIME);
    localparam logic [CNT_W:0] RED_HI    = hi_of(RED_TIME);
    localparam logic [CNT_W:0] RED_OV    = ov_of(RED_TIME);
    localparam logic [CNT_W:0] ORANGE_LO = lo_of(ORANGE_TIME);
    localparam logic [CNT_W:0] ORANGE_HI = hi_of(ORANGE_TIME);
    localparam logic [CNT_W:0] ORANGE_OV = ov_of(ORANGE_TIME);
    localparam logic [CNT_W:0] GREEN_LO  = lo_of(GREEN_TIME);
    localparam logic [CNT_W:0] GREEN_HI  = hi_of(GREEN_TIME);
    localparam logic [CNT_W:0] GREEN_OV  = ov_of(GREEN_TIME);

    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    // Registered lamp sample.
    logic red_q, ora_q, gre_q;

    // FSM and measurement state.
    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic               from_sync_q, from_sync_d;
    logic [CNT_W-1:0]   dur_q, dur_d;
    logic               dur_valid_q, dur_valid_d;
    logic [7:0]         cycle_cnt_q, cycle_cnt_d;
    logic [DRUN_W-1:0]  dark_run_q, dark_run_d;

    // Sticky faults.
    logic fault_multi_q, fault_multi_d;
    logic fault_dark_q, fault_dark_d;
    logic fault_seq_q, fault_seq_d;
    logic fault_time_q, fault_time_d;
    logic fault_q, fault_d;

    // Decoded sample and per-phase bounds.
    logic [1:0]       lamp_sum_s;
    logic             sample_single_s;
    logic             sample_dark_s;
    logic             sample_multi_s;
    state_t           sample_state_s;
    logic [CNT_W:0]   lo_s, hi_s, ov_s;
    logic [CNT_W:0]   cnt_ext_s;
    logic [CNT_W:0]   cnt_inc_ext_s;
    logic             set_time_s;
    logic             set_seq_s;
    logic             set_dark_s;

    // Decode the registered lamp sample into a single lamp, DARK or MULTI.
    always_comb begin
        lamp_sum_s      = {1'b0, red_q} + {1'b0, ora_q} + {1'b0, gre_q};
        sample_single_s = (lamp_sum_s == 2'd1);
        sample_dark_s   = (lamp_sum_s == 2'd0);
        sample_multi_s  = (lamp_sum_s >= 2'd2);
        case ({red_q, ora_q, gre_q})
            3'b100:  sample_state_s = ST_RED;
            3'b010:  sample_state_s = ST_ORANGE;
            3'b001:  sample_state_s = ST_GREEN;
            default: sample_state_s = ST_SYNC;
        endcase
    end

    // Select the tolerance window of the current phase.
    always_comb begin
        case (state_q)
            ST_RED: begin
                lo_s = RED_LO;
                hi_s = RED_HI;
                ov_s = RED_OV;
            end
            ST_ORANGE: begin
                lo_s = ORANGE_LO;
                hi_s = ORANGE_HI;
                ov_s = ORANGE_OV;
            end
            ST_GREEN: begin
                lo_s = GREEN_LO;
                hi_s = GREEN_HI;
                ov_s = GREEN_OV;
            end
            default: begin
                lo_s = {(CNT_W+1){1'b0}};
                hi_s = {(CNT_W+1){1'b0}};
                ov_s = {(CNT_W+1){1'b0}};
            end
        endcase
    end

    // Phase FSM: tracking, duration measurement, sequence and timing checks.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        from_sync_d   = from_sync_q;
        dur_d         = dur_q;
        dur_valid_d   = 1'b0;
        cycle_cnt_d   = cycle_cnt_q;
        set_time_s    = 1'b0;
        set_seq_s     = 1'b0;
        cnt_ext_s     = {1'b0, cnt_q};
        cnt_inc_ext_s = {1'b0, cnt_q} + {{CNT_W{1'b0}}, 1'b1};

        case (state_q)
            ST_SYNC: begin
                // Lock onto the first clean lamp; its phase may be partial,
                // so its length is exempt from the time check.
                if (sample_single_s) begin
                    state_d     = sample_state_s;
                    cnt_d       = CNT_ONE;
                    from_sync_d = 1'b1;
                end else begin
                    state_d     = ST_SYNC;
                end
            end
            ST_RED, ST_ORANGE, ST_GREEN: begin
                if (sample_single_s && (sample_state_s != state_q)) begin
                    dur_d       = cnt_q;
                    dur_valid_d = 1'b1;
                    if (!from_sync_q && ((cnt_ext_s < lo_s) || (cnt_ext_s > hi_s))) begin
                        set_time_s = 1'b1;
                    end else begin
                        set_time_s = 1'b0;
                    end
                    if (sample_state_s != successor(state_q)) begin
                        set_seq_s = 1'b1;
                    end else if (state_q == ST_GREEN) begin
                        cycle_cnt_d = cycle_cnt_q + 8'd1;
                    end else begin
                        set_seq_s = 1'b0;
                    end
                    state_d     = sample_state_s;
                    cnt_d       = CNT_ONE;
                    from_sync_d = 1'b0;
                end else begin
                    // Same lamp, DARK or MULTI: the phase keeps running.
                    // The overrun flag fires once, on the step that crosses
                    // the upper bound, so it does not block clr_fault later.
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + CNT_ONE;
                        if (cnt_inc_ext_s == ov_s) begin
                            set_time_s = 1'b1;
                        end else begin
                            set_time_s = 1'b0;
                        end
                    end else begin
                        cnt_d = CNT_MAX;
                    end
                end
            end
            default: begin
                state_d = ST_SYNC;
                cnt_d   = {CNT_W{1'b0}};
            end
        endcase
    end

    // Dark run counter and sticky fault flags; a new event beats clr_fault.
    always_comb begin
        set_dark_s = 1'b0;
        if (sample_dark_s) begin
            if (dark_run_q == DRUN_W'(DARK_MAX)) begin
                set_dark_s = 1'b1;
            end else begin
                set_dark_s = 1'b0;
            end
            if (dark_run_q == DRUN_W'(DARK_MAX + 1)) begin
                dark_run_d = dark_run_q;
            end else begin
                dark_run_d = dark_run_q + {{(DRUN_W-1){1'b0}}, 1'b1};
            end
        end else begin
            dark_run_d = {DRUN_W{1'b0}};
        end

        fault_multi_d = sample_multi_s ? 1'b1 : (clr_fault ? 1'b0 : fault_multi_q);
        fault_dark_d  = set_dark_s     ? 1'b1 : (clr_fault ? 1'b0 : fault_dark_q);
        fault_seq_d   = set_seq_s      ? 1'b1 : (clr_fault ? 1'b0 : fault_seq_q);
        fault_time_d  = set_time_s     ? 1'b1 : (clr_fault ? 1'b0 : fault_time_q);
        fault_d       = fault_multi_d | fault_dark_d | fault_seq_d | fault_time_d;
    end

    // All state, with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            red_q         <= 1'b0;
            ora_q         <= 1'b0;
            gre_q         <= 1'b0;
            state_q       <= ST_SYNC;
            cnt_q         <= {CNT_W{1'b0}};
            from_sync_q   <= 1'b0;
            dur_q         <= {CNT_W{1'b0}};
            dur_valid_q   <= 1'b0;
            cycle_cnt_q   <= 8'd0;
            dark_run_q    <= {DRUN_W{1'b0}};
            fault_multi_q <= 1'b0;
            fault_dark_q  <= 1'b0;
            fault_seq_q   <= 1'b0;
            fault_time_q  <= 1'b0;
            fault_q       <= 1'b0;
        end else begin
            red_q         <= redlight;
            ora_q         <= oralight;
            gre_q         <= grelight;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            from_sync_q   <= from_sync_d;
            dur_q         <= dur_d;
            dur_valid_q   <= dur_valid_d;
            cycle_cnt_q   <= cycle_cnt_d;
            dark_run_q    <= dark_run_d;
            fault_multi_q <= fault_multi_d;
            fault_dark_q  <= fault_dark_d;
            fault_seq_q   <= fault_seq_d;
            fault_time_q  <= fault_time_d;
            fault_q       <= fault_d;
        end
    end

    assign phase       = state_q;
    assign dur         = dur_q;
    assign dur_valid   = dur_valid_q;
    assign cycle_cnt   = cycle_cnt_q;
    assign fault_multi = fault_multi_q;
    assign fault_dark  = fault_dark_q;
    assign fault_seq   = fault_seq_q;
    assign fault_time  = fault_time_q;
    assign fault       = fault_q;

endmodule

// File: tb/tb_traffic_light_monitor.sv
// ---------------------------------------------------------------------------
// tb_traffic_light_monitor
//
// Directed bench for traffic_light_monitor. Lamp inputs change 1 time unit
// after a rising edge; the DUT registers them on the next edge and the FSM
// reacts one edge later, so change() (two edges) ends just after the DUT has
// switched phase. Outputs are sampled 1 time unit after the edge.
// ---------------------------------------------------------------------------
module tb_traffic_light_monitor;

    logic       clk;
    logic       rst_n;
    logic       redlight, oralight, grelight;
    logic       clr_fault;
    logic [1:0] phase;
    logic [5:0] dur;
    logic       dur_valid;
    logic [7:0] cycle_cnt;
    logic       fault_multi, fault_dark, fault_seq, fault_time, fault;

    int n_checks = 0;
    int n_fail   = 0;

    traffic_light_monitor dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .redlight    (redlight),
        .oralight    (oralight),
        .grelight    (grelight),
        .clr_fault   (clr_fault),
        .phase       (phase),
        .dur         (dur),
        .dur_valid   (dur_valid),
        .cycle_cnt   (cycle_cnt),
        .fault_multi (fault_multi),
        .fault_dark  (fault_dark),
        .fault_seq   (fault_seq),
        .fault_time  (fault_time),
        .fault       (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic chk_faults(input string tag, input logic m, input logic d,
                              input logic s, input logic t);
        chk({tag, "_multi"}, {31'd0, fault_multi}, {31'd0, m});
        chk({tag, "_dark"},  {31'd0, fault_dark},  {31'd0, d});
        chk({tag, "_seq"},   {31'd0, fault_seq},   {31'd0, s});
        chk({tag, "_time"},  {31'd0, fault_time},  {31'd0, t});
        chk({tag, "_fault"}, {31'd0, fault},       {31'd0, (m | d | s | t)});
    endtask

    task automatic hold(input logic r, input logic o, input logic g, input int n);
        redlight = r;
        oralight = o;
        grelight = g;
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic change(input logic r, input logic o, input logic g);
        hold(r, o, g, 2);
    endtask

    initial begin
        rst_n = 1'b0; clr_fault = 1'b0;
        redlight = 1'b0; oralight = 1'b0; grelight = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_phase", {30'd0, phase}, 32'd0);
        chk("rst_dur", {26'd0, dur}, 32'd0);
        chk("rst_dv", {31'd0, dur_valid}, 32'd0);
        chk("rst_cyc", {24'd0, cycle_cnt}, 32'd0);
        chk_faults("rst", 1'b0, 1'b0, 1'b0, 1'b0);
        rst_n = 1'b1;

        // Two legal cycles, first red entered from SYNC.
        change(1'b1, 1'b0, 1'b0);
        chk("t1_red0_phase", {30'd0, phase}, 32'd1);
        chk("t1_red0_dv", {31'd0, dur_valid}, 32'd0);
        hold(1'b1, 1'b0, 1'b0, 7);
        change(1'b0, 1'b1, 1'b0);
        chk("t1_or0_phase", {30'd0, phase}, 32'd2);
        chk("t1_or0_dur", {26'd0, dur}, 32'd9);
        chk("t1_or0_dv", {31'd0, dur_valid}, 32'd1);
        hold(1'b0, 1'b1, 1'b0, 1);
        chk("t1_dv_pulse", {31'd0, dur_valid}, 32'd0);
        change(1'b0, 1'b0, 1'b1);
        chk("t1_gr0_phase", {30'd0, phase}, 32'd3);
        chk("t1_gr0_dur", {26'd0, dur}, 32'd3);
        hold(1'b0, 1'b0, 1'b1, 10);
        change(1'b1, 1'b0, 1'b0);
        chk("t1_red1_phase", {30'd0, phase}, 32'd1);
        chk("t1_red1_dur", {26'd0, dur}, 32'd12);
        chk("t1_red1_cyc", {24'd0, cycle_cnt}, 32'd1);
        hold(1'b1, 1'b0, 1'b0, 7);
        change(1'b0, 1'b1, 1'b0);
        chk("t1_or1_dur", {26'd0, dur}, 32'd9);
        hold(1'b0, 1'b1, 1'b0, 1);
        change(1'b0, 1'b0, 1'b1);
        chk("t1_gr1_dur", {26'd0, dur}, 32'd3);
        hold(1'b0, 1'b0, 1'b1, 10);
        change(1'b1, 1'b0, 1'b0);
        chk("t1_red2_phase", {30'd0, phase}, 32'd1);
        chk("t1_red2_dur", {26'd0, dur}, 32'd12);
        chk("t1_red2_cyc", {24'd0, cycle_cnt}, 32'd2);
        chk_faults("t1", 1'b0, 1'b0, 1'b0, 1'b0);

        // Red overrun: flagged as count reaches 11, before orange appears.
        hold(1'b1, 1'b0, 1'b0, 9);
        chk("t2_cnt10_time", {31'd0, fault_time}, 32'd0);
        hold(1'b1, 1'b0, 1'b0, 1);
        chk("t2_cnt11_phase", {30'd0, phase}, 32'd1);
        chk_faults("t2_ovr", 1'b0, 1'b0, 1'b0, 1'b1);
        change(1'b0, 1'b1, 1'b0);
        chk("t2_or_dur", {26'd0, dur}, 32'd12);
        chk("t2_or_phase", {30'd0, phase}, 32'd2);
        clr_fault = 1'b1;
        hold(1'b0, 1'b1, 1'b0, 1);
        clr_fault = 1'b0;
        chk_faults("t2_clr", 1'b0, 1'b0, 1'b0, 1'b0);
        change(1'b0, 1'b0, 1'b1);
        chk("t2_gr_dur", {26'd0, dur}, 32'd3);
        hold(1'b0, 1'b0, 1'b1, 10);
        change(1'b1, 1'b0, 1'b0);
        chk("t2_red_dur", {26'd0, dur}, 32'd12);
        chk("t2_red_cyc", {24'd0, cycle_cnt}, 32'd3);
        chk_faults("t2_end", 1'b0, 1'b0, 1'b0, 1'b0);

        // Red straight to green: sequence fault, cycle_cnt unchanged.
        hold(1'b1, 1'b0, 1'b0, 7);
        change(1'b0, 1'b0, 1'b1);
        chk("t3_phase", {30'd0, phase}, 32'd3);
        chk("t3_dur", {26'd0, dur}, 32'd9);
        chk("t3_cyc", {24'd0, cycle_cnt}, 32'd3);
        chk_faults("t3", 1'b0, 1'b0, 1'b1, 1'b0);
        clr_fault = 1'b1;
        hold(1'b0, 1'b0, 1'b1, 1);
        clr_fault = 1'b0;
        chk("t3_clr_seq", {31'd0, fault_seq}, 32'd0);
        hold(1'b0, 1'b0, 1'b1, 9);
        change(1'b1, 1'b0, 1'b0);
        chk("t3_red_dur", {26'd0, dur}, 32'd12);
        chk("t3_red_cyc", {24'd0, cycle_cnt}, 32'd4);

        // Red+orange for one sample mid-red: counted as red time.
        hold(1'b1, 1'b0, 1'b0, 3);
        hold(1'b1, 1'b1, 1'b0, 1);
        hold(1'b1, 1'b0, 1'b0, 1);
        chk("t4_phase", {30'd0, phase}, 32'd1);
        chk_faults("t4_multi", 1'b1, 1'b0, 1'b0, 1'b0);
        hold(1'b1, 1'b0, 1'b0, 2);
        change(1'b0, 1'b1, 1'b0);
        chk("t4_or_phase", {30'd0, phase}, 32'd2);
        chk("t4_or_dur", {26'd0, dur}, 32'd9);
        chk_faults("t4_or", 1'b1, 1'b0, 1'b0, 1'b0);

        // Dark runs inside green: 2 tolerated, 3 flagged.
        hold(1'b0, 1'b1, 1'b0, 1);
        change(1'b0, 1'b0, 1'b1);
        chk("t5_gr_dur", {26'd0, dur}, 32'd3);
        hold(1'b0, 1'b0, 1'b1, 2);
        hold(1'b0, 1'b0, 1'b0, 2);
        hold(1'b0, 1'b0, 1'b1, 1);
        chk("t5_dark2", {31'd0, fault_dark}, 32'd0);
        chk("t5_dark2_phase", {30'd0, phase}, 32'd3);
        hold(1'b0, 1'b0, 1'b1, 1);
        hold(1'b0, 1'b0, 1'b0, 3);
        chk("t5_dark3_pre", {31'd0, fault_dark}, 32'd0);
        hold(1'b0, 1'b0, 1'b1, 1);
        chk_faults("t5_dark3", 1'b1, 1'b1, 1'b0, 1'b0);
        change(1'b1, 1'b0, 1'b0);
        chk("t5_red_dur", {26'd0, dur}, 32'd12);
        chk("t5_red_cyc", {24'd0, cycle_cnt}, 32'd5);

        // clr_fault on the same edge as a new MULTI: the set wins.
        hold(1'b1, 1'b0, 1'b0, 2);
        hold(1'b1, 1'b1, 1'b0, 1);
        clr_fault = 1'b1;
        hold(1'b1, 1'b0, 1'b0, 1);
        clr_fault = 1'b0;
        chk_faults("t5_setwins", 1'b1, 1'b0, 1'b0, 1'b0);
        clr_fault = 1'b1;
        hold(1'b1, 1'b0, 1'b0, 1);
        clr_fault = 1'b0;
        chk_faults("t5_clr", 1'b0, 1'b0, 1'b0, 1'b0);
        hold(1'b1, 1'b0, 1'b0, 2);
        change(1'b0, 1'b1, 1'b0);
        chk("t5_or_dur", {26'd0, dur}, 32'd9);

        // Reset mid-green, then resynchronise on a short orange.
        hold(1'b0, 1'b1, 1'b0, 1);
        change(1'b0, 1'b0, 1'b1);
        hold(1'b0, 1'b0, 1'b1, 3);
        rst_n = 1'b0;
        hold(1'b0, 1'b0, 1'b1, 1);
        rst_n = 1'b1;
        chk("t6_rst_phase", {30'd0, phase}, 32'd0);
        chk("t6_rst_dur", {26'd0, dur}, 32'd0);
        chk("t6_rst_cyc", {24'd0, cycle_cnt}, 32'd0);
        chk("t6_rst_dv", {31'd0, dur_valid}, 32'd0);
        chk_faults("t6_rst", 1'b0, 1'b0, 1'b0, 1'b0);
        hold(1'b0, 1'b1, 1'b0, 1);
        hold(1'b0, 1'b0, 1'b1, 1);
        chk("t6_or_phase", {30'd0, phase}, 32'd2);
        chk("t6_or_dv", {31'd0, dur_valid}, 32'd0);
        chk("t6_or_seq", {31'd0, fault_seq}, 32'd0);
        hold(1'b0, 1'b0, 1'b1, 1);
        chk("t6_gr_phase", {30'd0, phase}, 32'd3);
        chk("t6_gr_dur", {26'd0, dur}, 32'd1);
        chk("t6_gr_dv", {31'd0, dur_valid}, 32'd1);
        chk_faults("t6_gr", 1'b0, 1'b0, 1'b0, 1'b0);

        // Checked red that is too short (7 < 8).
        hold(1'b0, 1'b0, 1'b1, 10);
        change(1'b1, 1'b0, 1'b0);
        chk("t7_red_dur", {26'd0, dur}, 32'd12);
        chk("t7_red_cyc", {24'd0, cycle_cnt}, 32'd1);
        hold(1'b1, 1'b0, 1'b0, 5);
        change(1'b0, 1'b1, 1'b0);
        chk("t7_or_dur", {26'd0, dur}, 32'd7);
        chk_faults("t7_short", 1'b0, 1'b0, 1'b0, 1'b1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
